// File: rtl/seq_divider.sv
// seq_divider
//   Sequential signed divider: a 2N-bit dividend divided by an N-bit divisor,
//   one restoring step per clock on operand magnitudes, with the signs
//   re-applied in a final FIX cycle. Quotient truncates toward zero; the
//   remainder takes the sign of the dividend.
//
// Ports
//   clk       rising-edge clock for all state
//   rst       synchronous active-high reset
//   start     request, only looked at while IDLE
//   dividend  2N-bit signed numerator, captured when start is accepted
//   divisor   N-bit signed denominator, captured when start is accepted
//   quot      N-bit signed quotient (saturated when it does not fit)
//   rem       N-bit signed remainder, always exact
//   busy      high while the division is in progress (CALC and FIX)
//   done      one-cycle pulse, results valid
//   div_zero  the current result came from a zero divisor
//   overflow  the true quotient did not fit in N signed bits
module seq_divider #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quot,
  output logic [N-1:0]   rem,
  output logic           busy,
  output logic           done,
  output logic           div_zero,
  output logic           overflow
);

  localparam int CW = $clog2(2*N);
  localparam logic [CW-1:0] LAST_STEP = CW'(2*N-1);

  // Largest quotient magnitudes that still fit N signed bits.
  localparam logic [2*N-1:0] MAG_NEG_LIM = (2*N)'(1) << (N-1);
  localparam logic [2*N-1:0] MAG_POS_LIM = MAG_NEG_LIM - (2*N)'(1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [CW-1:0]  step_cnt;
  logic [2*N-1:0] q_mag;
  logic [N-1:0]   pr;
  logic [N-1:0]   dvs_mag;
  logic           q_neg;
  logic           r_neg;

  logic [2*N-1:0] dividend_mag;
  logic [N-1:0]   divisor_mag;
  logic           divisor_is_zero;
  logic [N:0]     trial;
  logic           trial_fits;
  logic [N-1:0]   pr_sub;
  logic           q_in_range;
  logic [N-1:0]   q_signed_low;
  logic [N-1:0]   rem_signed;

  // Operand magnitudes and the per-cycle restoring step. The most negative
  // operand values negate onto themselves, which read as unsigned is exactly
  // their magnitude. The shifted partial remainder needs N+1 bits, but once
  // the divisor magnitude is subtracted the result is below that magnitude
  // and fits back in N bits, so the subtraction is done at N-bit width.
  always_comb begin
    dividend_mag    = dividend[2*N-1] ? -dividend : dividend;
    divisor_mag     = divisor[N-1] ? -divisor : divisor;
    divisor_is_zero = (divisor == '0);
    trial           = {pr, q_mag[2*N-1]};
    trial_fits      = (trial >= {1'b0, dvs_mag});
    pr_sub          = trial[N-1:0] - dvs_mag;
  end

  // Sign fix-up used in the FIX cycle. Only the low N bits of the signed
  // quotient are ever driven out, and the low bits of a negation depend only
  // on the low bits of its operand, so the full 2N-bit negation is not built.
  always_comb begin
    q_in_range   = q_neg ? (q_mag <= MAG_NEG_LIM) : (q_mag <= MAG_POS_LIM);
    q_signed_low = q_neg ? -q_mag[N-1:0] : q_mag[N-1:0];
    rem_signed   = r_neg ? -pr : pr;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips the arithmetic entirely and goes
  // straight to DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_is_zero ? DONE : CALC;
        end
      end
      CALC: begin
        if (step_cnt == LAST_STEP) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status output decoded from the state register only.
  always_comb begin
    busy = 1'b0;
    if (state == CALC || state == FIX) begin
      busy = 1'b1;
    end
  end

  // Datapath and result registers. Results change only on the edge that
  // enters DONE; done itself is registered from DONE, so it pulses in the
  // following cycle while the FSM is already back in IDLE and able to
  // accept a back-to-back start.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
      q_mag    <= '0;
      pr       <= '0;
      dvs_mag  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      quot     <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            q_mag    <= dividend_mag;
            pr       <= '0;
            dvs_mag  <= divisor_mag;
            q_neg    <= dividend[2*N-1] ^ divisor[N-1];
            r_neg    <= dividend[2*N-1];
            step_cnt <= '0;
            if (divisor_is_zero) begin
              quot     <= '0;
              rem      <= '0;
              div_zero <= 1'b1;
              overflow <= 1'b0;
            end
          end
        end
        CALC: begin
          step_cnt <= step_cnt + 1'b1;
          if (trial_fits) begin
            pr    <= pr_sub;
            q_mag <= {q_mag[2*N-2:0], 1'b1};
          end else begin
            pr    <= trial[N-1:0];
            q_mag <= {q_mag[2*N-2:0], 1'b0};
          end
        end
        FIX: begin
          div_zero <= 1'b0;
          rem      <= rem_signed;
          if (q_in_range) begin
            overflow <= 1'b0;
            quot     <= q_signed_low;
          end else begin
            overflow <= 1'b1;
            quot     <= q_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
